// File: rtl/ssp_rx_fifo_ctrl.sv
// SSP receive-side FIFO controller: captures deserialized words into a circular
// buffer, serves a show-ahead consumer, and sequences enable/flush/overrun recovery.
module ssp_rx_fifo_ctrl #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          SSPCLKIN,
    input  logic          CLEAR,
    input  logic          RX_EN,
    input  logic [N-1:0]  RxData,
    input  logic          receive_signal,
    input  logic          RD_REQ,
    input  logic          OE_CLR,
    input  logic [AW:0]   RX_THRESH,
    output logic [N-1:0]  RD_DATA,
    output logic          RD_VALID,
    output logic          FIFO_FULL,
    output logic [AW:0]   LEVEL,
    output logic          SSPRXINTR,
    output logic          SSPOEINTR,
    output logic [1:0]    RX_STATE
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_RUN      = 2'b01,
        ST_OVERRUN  = 2'b10
    } rx_state_e;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    rx_state_e       state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [N-1:0]    rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            full_q, full_d;
    logic            rx_intr_q, rx_intr_d;
    logic            oe_intr_q, oe_intr_d;
    logic [N-1:0]    mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic            flush;
    logic            ovr_cond;

    // Flush wins over any strobe in the cycle RX_EN drops, so a flush is never an overrun.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        oe_intr_d = oe_intr_q;

        pop      = RD_REQ & rd_valid_q;
        flush    = ~RX_EN | (state_q == ST_DISABLED);
        ovr_cond = RX_EN & receive_signal & full_q & ~pop & (state_q != ST_DISABLED);
        push     = RX_EN & receive_signal & (state_q == ST_RUN) & (~full_q | pop);

        case (state_q)
            ST_DISABLED: if (RX_EN) state_d = ST_RUN;
            ST_RUN: begin
                if (!RX_EN)        state_d = ST_DISABLED;
                else if (ovr_cond) state_d = ST_OVERRUN;
            end
            ST_OVERRUN: begin
                if (!RX_EN)                   state_d = ST_DISABLED;
                else if (OE_CLR && !ovr_cond) state_d = ST_RUN;
            end
            default: state_d = ST_DISABLED;
        endcase

        // A fresh overrun beats a same-cycle clear.
        if (ovr_cond)    oe_intr_d = 1'b1;
        else if (OE_CLR) oe_intr_d = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // Bypass the word being written when it becomes the new head this cycle.
        if (push && (wr_ptr_q == rd_ptr_d)) rd_data_d = RxData;
        else                                rd_data_d = mem_q[rd_ptr_d];

        rd_valid_d = (level_d != '0);
        full_d     = (level_d == DEPTH_L);
        rx_intr_d  = (RX_THRESH != '0) && (level_d >= RX_THRESH);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge SSPCLKIN or posedge CLEAR) begin
        if (CLEAR) begin
            state_q    <= ST_DISABLED;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            rx_intr_q  <= 1'b0;
            oe_intr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            rx_intr_q  <= rx_intr_d;
            oe_intr_q  <= oe_intr_d;
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by pointers and LEVEL.
    always_ff @(posedge SSPCLKIN) begin
        if (push) mem_q[wr_ptr_q] <= RxData;
    end

    assign RD_DATA   = rd_data_q;
    assign RD_VALID  = rd_valid_q;
    assign FIFO_FULL = full_q;
    assign LEVEL     = level_q;
    assign SSPRXINTR = rx_intr_q;
    assign SSPOEINTR = oe_intr_q;
    assign RX_STATE  = state_q;

endmodule

// File: tb/tb_ssp_rx_fifo_ctrl.sv
// Directed bench for ssp_rx_fifo_ctrl: a queue-based model checked every cycle,
// plus hand-computed literal expectations from the test plan.
module tb_ssp_rx_fifo_ctrl;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          CLEAR;
    logic          RX_EN;
    logic [N-1:0]  RxData;
    logic          receive_signal;
    logic          RD_REQ;
    logic          OE_CLR;
    logic [AW:0]   RX_THRESH;
    logic [N-1:0]  RD_DATA;
    logic          RD_VALID;
    logic          FIFO_FULL;
    logic [AW:0]   LEVEL;
    logic          SSPRXINTR;
    logic          SSPOEINTR;
    logic [1:0]    RX_STATE;

    int n_pass  = 0;
    int n_total = 0;

    ssp_rx_fifo_ctrl #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .SSPCLKIN       (clk),
        .CLEAR          (CLEAR),
        .RX_EN          (RX_EN),
        .RxData         (RxData),
        .receive_signal (receive_signal),
        .RD_REQ         (RD_REQ),
        .OE_CLR         (OE_CLR),
        .RX_THRESH      (RX_THRESH),
        .RD_DATA        (RD_DATA),
        .RD_VALID       (RD_VALID),
        .FIFO_FULL      (FIFO_FULL),
        .LEVEL          (LEVEL),
        .SSPRXINTR      (SSPRXINTR),
        .SSPOEINTR      (SSPOEINTR),
        .RX_STATE       (RX_STATE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: stored words as a queue, state as 0 disabled / 1 run / 2 overrun.
    logic [N-1:0] q[$];
    int           m_state = 0;
    bit           m_oe    = 1'b0;
    bit           m_intr  = 1'b0;
    int           sz;
    bit           do_pop;
    bit           was_full;
    bit           ovr;

    always @(posedge clk or posedge CLEAR) begin
        if (CLEAR) begin
            q.delete();
            m_state = 0;
            m_oe    = 1'b0;
            m_intr  = 1'b0;
        end else begin
            sz       = q.size();
            do_pop   = RD_REQ && (sz > 0);
            was_full = (sz == DEPTH);
            ovr      = RX_EN && receive_signal && was_full && !do_pop && (m_state != 0);
            if (!RX_EN || m_state == 0) begin
                // Disabled or being disabled: everything stored is discarded.
                q.delete();
                if (OE_CLR) m_oe = 1'b0;
                m_state = (m_state == 0 && RX_EN) ? 1 : 0;
            end else if (m_state == 1) begin
                if (ovr) begin
                    m_state = 2;
                    m_oe    = 1'b1;
                end else begin
                    if (OE_CLR) m_oe = 1'b0;
                    if (do_pop) void'(q.pop_front());
                    if (receive_signal) q.push_back(RxData);
                end
            end else begin
                if (do_pop) void'(q.pop_front());
                if (ovr) m_oe = 1'b1;
                else if (OE_CLR) begin
                    m_oe    = 1'b0;
                    m_state = 1;
                end
            end
            m_intr = (RX_THRESH != 0) && (q.size() >= int'(RX_THRESH));
        end
    end

    always @(negedge clk) begin
        check("level",  32'(LEVEL),     32'(q.size()));
        check("valid",  32'(RD_VALID),  32'(q.size() != 0));
        check("full",   32'(FIFO_FULL), 32'(q.size() == DEPTH));
        check("state",  32'(RX_STATE),  32'(m_state));
        check("oeintr", 32'(SSPOEINTR), 32'(m_oe));
        check("rxintr", 32'(SSPRXINTR), 32'(m_intr));
        if (q.size() != 0) check("head", 32'(RD_DATA), 32'(q[0]));
    end

    task automatic cyc(input bit en, input bit stb, input logic [N-1:0] d, input bit rd, input bit oc);
        RX_EN          = en;
        receive_signal = stb;
        RxData         = d;
        RD_REQ         = rd;
        OE_CLR         = oc;
        @(posedge clk);
        #2;
        receive_signal = 1'b0;
        RD_REQ         = 1'b0;
        OE_CLR         = 1'b0;
    endtask

    task automatic push(input logic [N-1:0] d);
        cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic fill_seq();
        for (int i = 0; i < DEPTH; i++) push(8'(17 * (i + 1)));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"}, 32'(LEVEL),     32'd0);
        check({tag, "_valid"}, 32'(RD_VALID),  32'd0);
        check({tag, "_data"},  32'(RD_DATA),   32'd0);
        check({tag, "_full"},  32'(FIFO_FULL), 32'd0);
        check({tag, "_state"}, 32'(RX_STATE),  32'd0);
        check({tag, "_oe"},    32'(SSPOEINTR), 32'd0);
        check({tag, "_rxi"},   32'(SSPRXINTR), 32'd0);
    endtask

    initial begin
        logic [N-1:0] v;
        CLEAR = 1'b1; RX_EN = 1'b0; RxData = '0; receive_signal = 1'b0;
        RD_REQ = 1'b0; OE_CLR = 1'b0; RX_THRESH = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_values("rst");
        CLEAR = 1'b0;

        // Enable, then a single word becomes visible after its edge.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("en_state", 32'(RX_STATE), 32'h1);
        push(8'hA5);
        check("a5_state", 32'(RX_STATE), 32'h1);
        check("a5_valid", 32'(RD_VALID), 32'h1);
        check("a5_data",  32'(RD_DATA),  32'hA5);
        check("a5_level", 32'(LEVEL),    32'h1);
        pop();

        // Fill/drain three times to wrap the pointers.
        for (int rep = 0; rep < 3; rep++) begin
            fill_seq();
            check("fill_full",  32'(FIFO_FULL), 32'h1);
            check("fill_level", 32'(LEVEL),     32'h4);
            for (int i = 0; i < DEPTH; i++) begin
                v = 8'(17 * (i + 1));
                check("order", 32'(RD_DATA), 32'(v));
                pop();
            end
            check("drain_valid", 32'(RD_VALID), 32'h0);
            check("drain_level", 32'(LEVEL),    32'h0);
        end

        // Overrun: dropped words never enter, pops still work, clear recovers.
        fill_seq();
        push(8'h55);
        check("ovr_oe",    32'(SSPOEINTR), 32'h1);
        check("ovr_state", 32'(RX_STATE),  32'h2);
        check("ovr_level", 32'(LEVEL),     32'h4);
        check("ovr_head",  32'(RD_DATA),   32'h11);
        cyc(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        check("ovr_pop_level", 32'(LEVEL),   32'h3);
        check("ovr_pop_head",  32'(RD_DATA), 32'h22);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("oeclr_state", 32'(RX_STATE),  32'h1);
        check("oeclr_oe",    32'(SSPOEINTR), 32'h0);
        for (int i = 1; i < DEPTH; i++) begin
            v = 8'(17 * (i + 1));
            check("ovr_order", 32'(RD_DATA), 32'(v));
            pop();
        end
        check("ovr_empty", 32'(RD_VALID), 32'h0);

        // Clear and a new overrun in the same cycle: the set wins.
        fill_seq();
        push(8'h99);
        cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
        check("setwin_state", 32'(RX_STATE),  32'h2);
        check("setwin_oe",    32'(SSPOEINTR), 32'h1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("ovr_dis_state", 32'(RX_STATE),  32'h0);
        check("ovr_dis_oe",    32'(SSPOEINTR), 32'h1);
        check("ovr_dis_level", 32'(LEVEL),     32'h0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("dis_oeclr", 32'(SSPOEINTR), 32'h0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Push and pop together when full, then when empty.
        fill_seq();
        cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        check("pp_full_level", 32'(LEVEL),     32'h4);
        check("pp_full_oe",    32'(SSPOEINTR), 32'h0);
        check("pp_full_state", 32'(RX_STATE),  32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == DEPTH - 1) ? 8'h77 : 8'(17 * (i + 2));
            check("pp_order", 32'(RD_DATA), 32'(v));
            pop();
        end
        cyc(1'b1, 1'b1, 8'h88, 1'b1, 1'b0);
        check("pp_empty_level", 32'(LEVEL),   32'h1);
        check("pp_empty_data",  32'(RD_DATA), 32'h88);
        pop();

        // Receive-level interrupt thresholds.
        RX_THRESH = 3'd2;
        push(8'h01);
        check("thr2_one", 32'(SSPRXINTR), 32'h0);
        push(8'h02);
        check("thr2_two", 32'(SSPRXINTR), 32'h1);
        pop();
        check("thr2_pop", 32'(SSPRXINTR), 32'h0);
        pop();
        RX_THRESH = 3'd0;
        fill_seq();
        check("thr0_full", 32'(SSPRXINTR), 32'h0);
        RX_THRESH = 3'd4;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("thr4_full", 32'(SSPRXINTR), 32'h1);
        RX_THRESH = 3'd5;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("thr5_full", 32'(SSPRXINTR), 32'h0);
        for (int i = 0; i < DEPTH; i++) pop();
        RX_THRESH = 3'd0;

        // Asynchronous reset in mid-cycle with three words stored.
        for (int i = 0; i < 3; i++) push(8'(17 * (i + 1)));
        check("pre_rst_level", 32'(LEVEL), 32'h3);
        #1 CLEAR = 1'b1;
        #1 check_reset_values("async");
        @(posedge clk);
        #2 CLEAR = 1'b0;

        // Dropping RX_EN flushes; strobes are ignored until it returns.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("re_state", 32'(RX_STATE), 32'h1);
        for (int i = 0; i < 3; i++) push(8'(17 * (i + 1)));
        cyc(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        check("flush_state", 32'(RX_STATE),  32'h0);
        check("flush_level", 32'(LEVEL),     32'h0);
        check("flush_valid", 32'(RD_VALID),  32'h0);
        check("flush_oe",    32'(SSPOEINTR), 32'h0);
        repeat (2) cyc(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
        check("dis_ignored", 32'(LEVEL), 32'h0);
        cyc(1'b1, 1'b1, 8'hDD, 1'b0, 1'b0);
        check("en_strobe_ignored", 32'(LEVEL), 32'h0);
        push(8'hEE);
        check("back_level", 32'(LEVEL),   32'h1);
        check("back_data",  32'(RD_DATA), 32'hEE);
        pop();
        repeat (2) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
